// File: rtl/term_cmd_sched.sv
// term_cmd_sched: FIFO-buffered byte decoder that issues gap-spaced terminal command pulses.
// Define TERM_ANSI_ESC_EN to decode ESC [ 2 J and ESC [ H as clear-home.
module term_cmd_sched #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CMD_GAP    = 2000
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [7:0]                  s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        i_btn_clear,
    output logic                        o_putchar,
    output logic [7:0]                  o_char,
    output logic                        o_clearhome,
    output logic                        o_cr,
    output logic                        o_lf,
    output logic                        o_bs,
    output logic [$clog2(FIFO_DEPTH):0] o_level
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CMD_GAP);
    localparam logic [CW-1:0] GAP_LOAD = CW'(CMD_GAP - 1);

`ifdef TERM_ANSI_ESC_EN
    typedef enum logic [2:0] {IDLE, GAP, ESC, CSI, CSI2} state_t;
`else
    typedef enum logic [0:0] {IDLE, GAP} state_t;
`endif
    typedef enum logic [2:0] {CMD_NONE, CMD_PUT, CMD_CLR, CMD_CR, CMD_LF, CMD_BS} cmd_t;

    state_t        state;
    state_t        next_parse;
    cmd_t          cmd;
    logic [CW-1:0] gap_cnt;
    logic          clr_pend;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [7:0]    head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          serve;

    assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty         = (wr_ptr == rd_ptr);
    assign s_axis_tready = !full;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign head          = mem[rd_ptr[AW-1:0]];
    assign o_level       = wr_ptr - rd_ptr;
    assign serve         = clr_pend && (state != GAP);
    assign pop           = !serve && !empty && (state != GAP);

    function automatic cmd_t decode(input logic [7:0] b);
        cmd_t c;
        c = CMD_NONE;
        if (b >= 8'h20 && b <= 8'h7E) c = CMD_PUT;
        else begin
            case (b)
                8'h0D:   c = CMD_CR;
                8'h0A:   c = CMD_LF;
                8'h08:   c = CMD_BS;
                8'h0C:   c = CMD_CLR;
                default: c = CMD_NONE;
            endcase
        end
        return c;
    endfunction

    always_comb begin
        cmd        = CMD_NONE;
        next_parse = IDLE;
`ifdef TERM_ANSI_ESC_EN
        case (state)
            ESC: begin
                if (head == 8'h5B)      next_parse = CSI;
                else if (head == 8'h1B) next_parse = ESC;
                else                    cmd = decode(head);
            end
            CSI: begin
                if (head == 8'h32)                      next_parse = CSI2;
                else if (head >= 8'h30 && head <= 8'h3F) next_parse = CSI;
                else if (head == 8'h48)                 cmd = CMD_CLR;
            end
            CSI2: begin
                if (head == 8'h4A) cmd = CMD_CLR;
            end
            default: begin
                if (head == 8'h1B) next_parse = ESC;
                else               cmd = decode(head);
            end
        endcase
`else
        cmd = decode(head);
`endif
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            clr_pend    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_putchar   <= 1'b0;
            o_char      <= '0;
            o_clearhome <= 1'b0;
            o_cr        <= 1'b0;
            o_lf        <= 1'b0;
            o_bs        <= 1'b0;
        end else begin
            o_putchar   <= 1'b0;
            o_clearhome <= 1'b0;
            o_cr        <= 1'b0;
            o_lf        <= 1'b0;
            o_bs        <= 1'b0;
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (i_btn_clear) clr_pend <= 1'b1;
            else if (serve)  clr_pend <= 1'b0;

            // Flush copies the pre-edge write pointer, so a same-cycle push survives.
            if (serve) begin
                rd_ptr      <= wr_ptr;
                o_clearhome <= 1'b1;
                state       <= GAP;
                gap_cnt     <= GAP_LOAD;
            end else if (state == GAP) begin
                // Leaving on 1 makes the next pulse land exactly CMD_GAP cycles later.
                if (gap_cnt <= CW'(1)) begin
                    gap_cnt <= '0;
                    state   <= IDLE;
                end else begin
                    gap_cnt <= gap_cnt - CW'(1);
                end
            end else if (pop) begin
                rd_ptr      <= rd_ptr + (AW+1)'(1);
                o_putchar   <= (cmd == CMD_PUT);
                o_clearhome <= (cmd == CMD_CLR);
                o_cr        <= (cmd == CMD_CR);
                o_lf        <= (cmd == CMD_LF);
                o_bs        <= (cmd == CMD_BS);
                if (cmd == CMD_PUT) o_char <= head;
                if (cmd != CMD_NONE) begin
                    state   <= GAP;
                    gap_cnt <= GAP_LOAD;
                end else begin
                    state <= next_parse;
                end
            end
        end
    end
endmodule

// File: doc/term_cmd_sched.md
# term_cmd_sched

Byte-stream command scheduler between the UART receiver's AXI-stream output and the terminal `control` block. It buffers received bytes in a small FIFO and decodes control characters and an optional ANSI clear sequence. It issues one-cycle command pulses (`putchar`, `clearhome`, `cr`, `lf`, `bs`) spaced by a guaranteed minimum gap, because `control` has no busy signal. It also arbitrates the push-button clear request against the byte stream.

## Interface
- `FIFO_DEPTH`, 16: byte FIFO entries; must be a power of two and at least 2.
- `CMD_GAP`, 2000: minimum clock cycles from one command pulse to the next; must be at least 2.
- `i_clk` in 1: system clock (12 MHz).
- `i_rst_n` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 8: received byte.
- `s_axis_tvalid` in 1: byte valid.
- `s_axis_tready` out 1: FIFO not full.
- `i_btn_clear` in 1: one-cycle clear request from the button.
- `o_putchar` out 1: one-cycle pulse; `o_char` is valid in the same cycle.
- `o_char` out 8: printable byte for `putchar`; holds its last value between pulses.
- `o_clearhome` out 1: one-cycle pulse.
- `o_cr`, `o_lf`, `o_bs` out 1 each: one-cycle cursor pulses.
- `o_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Reset values: all pulses 0, `o_char` = 0x00, `o_level` = 0, `s_axis_tready` = 1, FSM in IDLE, gap counter expired, clear-pending flag 0.
- Ingress:
  - A byte is written when `s_axis_tvalid && s_axis_tready`.
  - `s_axis_tready` = !full and is purely combinational from the pointers.
  - No byte is ever dropped at ingress.
- FIFO: binary read/write pointers, one extra wrap bit each.
  - Full means MSBs differ and the low bits are equal.
  - Empty means the pointers are equal.
- Clear pending:
  - `i_btn_clear` sets the flag; the flag stays set until it is serviced.
  - Servicing does the following in one cycle: flush the FIFO (read pointer := write pointer), reset the parser to IDLE, and issue `o_clearhome`.
  - A clear has priority over any FIFO byte.
  - A push accepted in the same cycle as the flush is kept.
- FSM states: IDLE, GAP, ESC, CSI, CSI2.
  - **IDLE, no clear pending, FIFO non-empty, gap expired:** pop one byte and decode it.
    - 0x20–0x7E: `o_putchar`, with `o_char` = byte.
    - 0x0D: `o_cr`.
    - 0x0A: `o_lf`.
    - 0x08: `o_bs`.
    - 0x0C: `o_clearhome`.
    - 0x1B: go to ESC with no pulse (only when the macro is defined).
    - Any other byte: discarded, no pulse, no gap.
  - **After any pulse:** go to GAP and load the counter with CMD_GAP−1. In GAP the counter decrements each cycle; at 0 the FSM returns to IDLE.
  - **ESC:** pops the next byte.
    - `[` goes to CSI.
    - Any other byte abandons the sequence and is decoded as in IDLE in the same cycle.
  - **CSI:**
    - `2` goes to CSI2.
    - Any other byte in 0x30–0x3F stays in CSI.
    - A final byte in 0x40–0x7E: `H` issues `o_clearhome`; any other final byte discards the sequence.
    - Bytes outside these ranges abort the sequence and go to IDLE with no pulse.
  - **CSI2:**
    - `J` issues `o_clearhome`.
    - Any other byte discards the sequence and goes to IDLE.
- At most one pulse output is high in any cycle.

## Timing
- Latency: a byte accepted at edge N, with the FSM in IDLE, the gap expired and the FIFO empty, produces its pulse in the cycle after edge N+1 (2-cycle latency).
- Spacing: consecutive pulses are exactly CMD_GAP cycles apart when the FIFO has backlog.
- A button clear arriving during GAP is serviced on the first IDLE cycle. It waits for the gap to expire.
- `i_rst_n` asserted mid-sequence or mid-gap forces all reset values immediately; FIFO contents are lost.
- Simultaneous push and pop: occupancy is unchanged, and a push into a full FIFO is allowed only when a pop happens in the same cycle. `s_axis_tready` remains !full, so this case never arises from ingress.

## Configuration
- `TERM_ANSI_ESC_EN` defined: the ESC, CSI and CSI2 states exist and `ESC [ 2 J` / `ESC [ H` produce `o_clearhome`.
- `TERM_ANSI_ESC_EN` undefined: the ESC, CSI and CSI2 states are not compiled. 0x1B is discarded like other non-printables, and following bytes such as `[2J` print as ordinary characters.

## Test plan
- Reset, then push 0x41: `o_putchar` pulses 2 cycles after acceptance with `o_char` = 0x41; all outputs held at reset values before that.
- Burst of 20 bytes with CMD_GAP=8 and FIFO_DEPTH=16: `s_axis_tready` drops at 16 entries, all 20 pulses are issued in order, and consecutive pulses are exactly 8 cycles apart.
- Push 0x0D, 0x0A, 0x08, 0x0C, 0x07: pulses in order `o_cr`, `o_lf`, `o_bs`, `o_clearhome`; no pulse for 0x07.
- With the macro defined, push 1B 5B 32 4A 41: a single `o_clearhome`, then `o_putchar` with 0x41. Without the macro: `putchar` pulses for `[`, `2`, `J`, `A`.
- Queue 5 bytes, then pulse `i_btn_clear` during GAP: at gap expiry one `o_clearhome` is issued, `o_level` becomes 0, and no `putchar` pulses follow.
- Deassert `i_rst_n` in CSI state with 3 bytes queued: outputs and `o_level` are 0 immediately, and after release 1B-free input decodes normally.
